apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Single-initiator APB3 master. Converts a simple valid/ready request from the CPU-side bus into APB SETUP/ACCESS transfers toward up to 4 APB slave peripherals (UART, GPIO, timer, ...).
- Decodes the slave select from the address, muxes the read data and ready signals back, and returns a one-cycle response.
- Bounds every transfer with a wait-state timeout so a hung slave cannot stall the CPU.

Parameters:
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles with PREADY low before abort; legal range 2..255.
- SLV_SEL_LSB, 12: LSB of the 2-bit slave-select field in req_addr. Slave n is selected when req_addr[SLV_SEL_LSB+1:SLV_SEL_LSB]==n.
- DEC_HI_LSB, 14: req_addr[31:DEC_HI_LSB] must be zero; otherwise the request is a decode error.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  read data; 0 for writes and for errors.
- rsp_err  out  1  decode error or timeout; valid with rsp_valid.
- PADDR  out  32  APB address (slaves use low bits).
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PENABLE  out  1  APB enable.
- PSEL  out  4  one-hot slave select.
- PRDATA0..PRDATA3  in  32 each  slave read data.
- PREADY0..PREADY3  in  1 each  slave ready.

Behaviour:
- Interface: one clock PCLK; reset PRESET is synchronous and active-high.
- Reset, at the first PCLK edge with PRESET=1: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, state=IDLE, timeout counter=0. req_ready=0 while PRESET=1.
- A reset during a transfer abandons it. No response is issued, and PSEL/PENABLE are 0 after that edge.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready=1 (combinational from state, gated by !PRESET).
  - A request is accepted at an edge where req_valid && req_ready.
  - On acceptance, req_addr, req_write and req_wdata are registered into PADDR/PWRITE/PWDATA, and the decoded one-hot is registered into PSEL.
  - Next state is SETUP. For a decode error, next state stays IDLE and no APB signal toggles.
- SETUP: PSEL one-hot, PENABLE=0 for exactly 1 cycle, then ACCESS.
- ACCESS:
  - PENABLE=1. The selected slave's PREADY is sampled each edge.
  - PREADY=1: PSEL=0, PENABLE=0; for reads, rsp_rdata captures the selected PRDATA, otherwise 0; rsp_err=0; rsp_valid=1; next state IDLE.
  - PREADY=0: increment the timeout counter. When the counter equals TIMEOUT_CYCLES-1 at a low-PREADY edge, abort: PSEL/PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, next state IDLE. The counter clears on leaving ACCESS.
- Decode error: rsp_valid=1, rsp_err=1, rsp_rdata=0 in the cycle after acceptance.
- rsp_valid is high for exactly one cycle. There is no response backpressure. rsp_rdata and rsp_err hold their value until the next response.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS, and hold their last value in IDLE.
- Latency, zero-wait slave: accept at edge E0; SETUP cycle after E0; ACCESS after E1; completion at E2; rsp_valid high in the cycle after E2.
- Each wait state adds 1 cycle.
- Back-to-back: req_ready=1 in the same cycle rsp_valid=1, so the next request is accepted at that edge. Minimum 3 cycles per transfer.
- Unselected PREADYn/PRDATAn are ignored. PREADY is ignored outside ACCESS.

Test Plan:
- Zero-wait write: req addr 0x0000_1004, wdata 0xA5, slave1 PREADY1=1 -> PSEL=4'b0010 for 2 cycles, PENABLE high 1 cycle, PADDR=0x1004, PWDATA=0xA5, rsp_valid 3 cycles after acceptance, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr 0x0000_0004, PREADY0 low 3 ACCESS cycles then high, PRDATA0=0x0000_0041 -> PENABLE high 4 cycles, rsp_rdata=0x41, rsp_err=0, rsp_valid 6 cycles after acceptance.
- Timeout: addr 0x0000_2000, PREADY2 held 0 -> abort after 16 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL back to 0, next request accepted.
- Decode error: addr 0x0001_0000 -> PSEL never asserts, rsp_valid/rsp_err=1 one cycle after acceptance.
- Back-to-back: req_valid held high for 2 reads to slaves 0 and 3, zero-wait -> second accepted in the rsp_valid cycle of the first, responses 3 cycles apart with the correct PRDATA each.
- Reset mid-ACCESS: PRESET=1 while PENABLE=1 -> after that edge PSEL=0, PENABLE=0, rsp_valid never pulses, req_ready=1 after PRESET drops.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Single-initiator APB3 master: valid/ready request -> SETUP/ACCESS on one of 4 slaves.
// Latency 3 cycles + wait states (timeout-bounded); req_ready only in IDLE, no response backpressure.
module apb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int SLV_SEL_LSB    = 12,
    parameter int DEC_HI_LSB     = 14
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PENABLE,
    output logic [3:0]  PSEL,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t      r_state;
    logic [7:0]  r_tmo_cnt;
    logic [1:0]  r_slv_idx;
    logic [31:0] r_paddr;
    logic        r_pwrite;
    logic [31:0] r_pwdata;
    logic        r_penable;
    logic [3:0]  r_psel;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_dec_err;
    logic [1:0]  w_slv;
    logic        w_pready;
    logic [31:0] w_prdata;

    assign req_ready = (r_state == S_IDLE) && !PRESET;
    assign w_accept  = req_valid && req_ready;
    assign w_dec_err = |req_addr[31:DEC_HI_LSB];
    assign w_slv     = req_addr[SLV_SEL_LSB+1:SLV_SEL_LSB];

    // Only the slave latched at acceptance is listened to.
    always_comb begin
        w_pready = 1'b0;
        w_prdata = 32'h0;
        case (r_slv_idx)
            2'd0: begin w_pready = PREADY0; w_prdata = PRDATA0; end
            2'd1: begin w_pready = PREADY1; w_prdata = PRDATA1; end
            2'd2: begin w_pready = PREADY2; w_prdata = PRDATA2; end
            2'd3: begin w_pready = PREADY3; w_prdata = PRDATA3; end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= S_IDLE;
            r_tmo_cnt   <= 8'd0;
            r_slv_idx   <= 2'd0;
            r_paddr     <= 32'h0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= 32'h0;
            r_penable   <= 1'b0;
            r_psel      <= 4'b0000;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_dec_err) begin
                            // Answered straight from IDLE; the APB side never moves.
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                        end else begin
                            r_paddr   <= req_addr;
                            r_pwrite  <= req_write;
                            r_pwdata  <= req_wdata;
                            r_psel    <= 4'b0001 << w_slv;
                            r_slv_idx <= w_slv;
                            r_state   <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_pready) begin
                        r_psel      <= 4'b0000;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_pwrite ? 32'h0 : w_prdata;
                        r_tmo_cnt   <= 8'd0;
                        r_state     <= S_IDLE;
                    end else if (r_tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        r_psel      <= 4'b0000;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                        r_tmo_cnt   <= 8'd0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign PENABLE   = r_penable;
    assign PSEL      = r_psel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: wait-state slave models plus a response scoreboard.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(.TIMEOUT_CYCLES(16), .SLV_SEL_LSB(12), .DEC_HI_LSB(14)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    // Slave models: ready after cfg_wait low ACCESS cycles, ready (ignored) otherwise.
    int cfg_wait [4];
    int wcnt [4];
    assign PRDATA0 = 32'h0000_0041;
    assign PRDATA1 = 32'h1111_1111;
    assign PRDATA2 = 32'h2222_2222;
    assign PRDATA3 = 32'hDEAD_0003;
    assign PREADY0 = (PSEL[0] && PENABLE) ? (wcnt[0] >= cfg_wait[0]) : 1'b1;
    assign PREADY1 = (PSEL[1] && PENABLE) ? (wcnt[1] >= cfg_wait[1]) : 1'b1;
    assign PREADY2 = (PSEL[2] && PENABLE) ? (wcnt[2] >= cfg_wait[2]) : 1'b1;
    assign PREADY3 = (PSEL[3] && PENABLE) ? (wcnt[3] >= cfg_wait[3]) : 1'b1;

    always @(posedge PCLK) begin
        for (int n = 0; n < 4; n++) begin
            if (PSEL[n] && PENABLE) wcnt[n] <= wcnt[n] + 1;
            else                    wcnt[n] <= 0;
        end
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        time         t_acc;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        e_mon;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_psel = 0, n_pen = 0, n_rsp = 0, n_unstable = 0;
    logic [31:0] s_paddr = '0, s_pwdata = '0;
    logic [3:0]  s_psel = '0;
    time         t_last = 0, t_prev = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge PCLK) begin
        if (PSEL != 4'b0000) n_psel++;
        if (PENABLE) n_pen++;
        if (PSEL != 4'b0000 && !PENABLE) begin
            s_paddr  = PADDR;
            s_pwdata = PWDATA;
            s_psel   = PSEL;
        end
        if (PENABLE && (PADDR != s_paddr || PWDATA != s_pwdata)) n_unstable++;
        if (rsp_valid) begin
            n_rsp++;
            t_prev = t_last;
            t_last = $time;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e_mon.err});
                chk("rsp_rdata", rsp_rdata, e_mon.rdata);
                chk("rsp_lat", 32'(($time - e_mon.t_acc) / 10), 32'(e_mon.lat));
            end
        end
    end

    // Present a request and hold it until accepted; expected response queued at the accepting edge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                        input bit hold);
        bit   ok;
        exp_t e;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                @(posedge PCLK);
                e.err   = exp_err;
                e.rdata = exp_rdata;
                e.lat   = exp_lat;
                e.t_acc = $time;
                exp_q.push_back(e);
                ok = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        chk("accept", {31'd0, ok}, 32'd1);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge PCLK);
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(negedge PCLK);
        #1;
    endtask

    task automatic clr();
        n_psel = 0;
        n_pen  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_snap;
        for (int n = 0; n < 4; n++) cfg_wait[n] = 0;
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_psel", {28'd0, PSEL}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
        clr();

        // zero-wait write to slave 1
        send(1'b1, 32'h0000_1004, 32'h0000_00A5, 1'b0, 32'h0, 2, 1'b0);
        drain();
        chk("wr_psel_cycles", 32'(n_psel), 32'd2);
        chk("wr_pen_cycles", 32'(n_pen), 32'd1);
        chk("wr_paddr", s_paddr, 32'h0000_1004);
        chk("wr_pwdata", s_pwdata, 32'h0000_00A5);
        chk("wr_psel", {28'd0, s_psel}, 32'h2);
        chk("wr_pwrite", {31'd0, PWRITE}, 32'd1);

        // read with 3 wait states from slave 0
        clr();
        cfg_wait[0] = 3;
        send(1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'h0000_0041, 5, 1'b0);
        drain();
        cfg_wait[0] = 0;
        chk("ws_pen_cycles", 32'(n_pen), 32'd4);
        chk("ws_psel", {28'd0, s_psel}, 32'h1);

        // hung slave 2 -> timeout after 16 ACCESS cycles
        clr();
        cfg_wait[2] = 1000;
        send(1'b0, 32'h0000_2000, 32'h0, 1'b1, 32'h0, 17, 1'b0);
        drain();
        cfg_wait[2] = 0;
        chk("to_pen_cycles", 32'(n_pen), 32'd16);
        chk("to_psel_after", {28'd0, PSEL}, 32'd0);
        send(1'b0, 32'h0000_2008, 32'h0, 1'b0, 32'h2222_2222, 2, 1'b0);
        drain();

        // decode error: bits above the select field set
        clr();
        send(1'b1, 32'h0001_0000, 32'h1234_5678, 1'b1, 32'h0, 0, 1'b0);
        drain();
        chk("de_psel_cycles", 32'(n_psel), 32'd0);
        chk("de_paddr_held", PADDR, 32'h0000_2008);

        // back-to-back reads to slaves 0 and 3
        send(1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0000_0041, 2, 1'b1);
        send(1'b0, 32'h0000_3000, 32'h0, 1'b0, 32'hDEAD_0003, 2, 1'b0);
        drain();
        chk("b2b_spacing", 32'((t_last - t_prev) / 10), 32'd3);
        chk("addr_stable", 32'(n_unstable), 32'd0);

        // reset in the middle of ACCESS
        cfg_wait[1] = 1000;
        send(1'b0, 32'h0000_1000, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (PENABLE) break;
            @(negedge PCLK);
        end
        chk("mid_penable", {31'd0, PENABLE}, 32'd1);
        rsp_snap = n_rsp;
        @(negedge PCLK);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        exp_q.delete();
        chk("mr_psel", {28'd0, PSEL}, 32'd0);
        chk("mr_penable", {31'd0, PENABLE}, 32'd0);
        chk("mr_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        cfg_wait[1] = 0;
        #1;
        chk("mr_req_ready_rel", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge PCLK);
        chk("mr_no_rsp", 32'(n_rsp), 32'(rsp_snap));
        send(1'b0, 32'h0000_1000, 32'h0, 1'b0, 32'h1111_1111, 2, 1'b0);
        drain();
        chk("rdata_held", rsp_rdata, 32'h1111_1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
